tcdm_bank_responder: RTL and testbench

- Bank-side endpoint of the narrow/wide TCDM request mux; one instance per SRAM bank.
- Accepts one multiplexed narrow request stream, which carries a wide flag, and drives a fixed-latency SRAM macro.
- Returns exactly one response per accepted request, echoing the wide flag and initiator address, through a credit-protected response FIFO.
- Never drops a response under downstream backpressure.

---
 rtl/tcdm_bank_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_tcdm_bank_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_responder.sv
// Bank-side endpoint of the narrow/wide TCDM request mux, one instance per SRAM bank.
// Accepts one request stream, drives a fixed-latency SRAM and returns exactly one in-order
// response per accepted request through a credit-protected fall-through FIFO.
// Optional performance counters are built when TCDM_BANK_RESPONDER_PERF_EN is defined.

module tcdm_bank_responder #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrWidth    = 10,
    parameter int unsigned IniAddrWidth = 8,
    parameter int unsigned SramLatency  = 1,
    parameter int unsigned RspFifoDepth = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // request side
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wide_i,
    input  logic                    req_wen_i,
    input  logic [DataWidth/8-1:0]  req_be_i,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [IniAddrWidth-1:0] req_ini_addr_i,
    // response side
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_wide_o,
    output logic [DataWidth-1:0]    rsp_rdata_o,
    output logic [IniAddrWidth-1:0] rsp_ini_addr_o,
    // SRAM macro
    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [AddrWidth-1:0]    sram_addr_o,
    output logic [DataWidth/8-1:0]  sram_be_o,
    output logic [DataWidth-1:0]    sram_wdata_o,
    input  logic [DataWidth-1:0]    sram_rdata_i,
    // performance counters
    output logic [31:0]             perf_narrow_o,
    output logic [31:0]             perf_wide_o,
    output logic [31:0]             perf_stall_o
);

    localparam int unsigned OccWidth = $clog2(RspFifoDepth + 1);
    localparam int unsigned PtrWidth = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;

    // Parameter legality checks at elaboration
    if (RspFifoDepth < SramLatency) begin : gen_depth_check
        $error("RspFifoDepth must be >= SramLatency");
    end
    if (SramLatency < 1 || SramLatency > 3) begin : gen_latency_check
        $error("SramLatency must be in 1..3");
    end
    if (DataWidth % 8 != 0) begin : gen_width_check
        $error("DataWidth must be a multiple of 8");
    end

    typedef struct packed {
        logic                    valid;
        logic                    wide;
        logic                    wen;
        logic [IniAddrWidth-1:0] ini_addr;
    } pipe_t;

    typedef struct packed {
        logic                    wide;
        logic [IniAddrWidth-1:0] ini_addr;
        logic [DataWidth-1:0]    rdata;
    } rsp_t;

    logic                req_hs;
    logic                rsp_hs;
    logic [OccWidth-1:0] occ_q, occ_d;

    pipe_t pipe_q [SramLatency];
    pipe_t pipe_d [SramLatency];
    pipe_t pipe_last;

    rsp_t                fifo_q [RspFifoDepth];
    logic [PtrWidth-1:0] fifo_wptr_q, fifo_wptr_d;
    logic [PtrWidth-1:0] fifo_rptr_q, fifo_rptr_d;
    logic [OccWidth-1:0] fifo_cnt_q, fifo_cnt_d;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                push_valid;
    rsp_t                push_entry;
    rsp_t                rsp_head;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(RspFifoDepth - 1)) begin
            return '0;
        end
        return ptr + PtrWidth'(1);
    endfunction

    // Credits: ready depends only on registered occupancy, never on a same-cycle pop
    assign req_ready_o = !rst_i && (occ_q < OccWidth'(RspFifoDepth));
    assign req_hs      = req_valid_i && req_ready_o;
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;

    // SRAM request is the accepted request itself
    assign sram_req_o   = req_hs;
    assign sram_we_o    = req_wen_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_be_o    = req_be_i;
    assign sram_wdata_o = req_wdata_i;

    // Occupancy next state: +1 on accept, -1 on response handshake
    always_comb begin
        occ_d = occ_q;
        case ({req_hs, rsp_hs})
            2'b10:   occ_d = occ_q + OccWidth'(1);
            2'b01:   occ_d = occ_q - OccWidth'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Occupancy register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Latency pipe shift: stage 0 captures the accepted request
    always_comb begin
        pipe_d[0].valid    = req_hs;
        pipe_d[0].wide     = req_wide_i;
        pipe_d[0].wen      = req_wen_i;
        pipe_d[0].ini_addr = req_ini_addr_i;
        for (int unsigned i = 1; i < SramLatency; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Latency pipe register; reset drops in-flight reads
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q <= '{default: '0};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign pipe_last  = pipe_q[SramLatency-1];
    assign push_valid = pipe_last.valid;

    // Entry pushed when SRAM data arrives; writes return zero data
    always_comb begin
        push_entry.wide     = pipe_last.wide;
        push_entry.ini_addr = pipe_last.ini_addr;
        push_entry.rdata    = pipe_last.wen ? {DataWidth{1'b0}} : sram_rdata_i;
    end

    // Fall-through: an arriving entry bypasses storage if the FIFO is empty and taken at once
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_pop   = !fifo_empty && rsp_ready_i;
    assign fifo_push  = push_valid && !(fifo_empty && rsp_ready_i);
    assign rsp_head   = fifo_empty ? push_entry : fifo_q[fifo_rptr_q];

    assign rsp_valid_o    = !rst_i && (!fifo_empty || push_valid);
    assign rsp_wide_o     = rsp_head.wide;
    assign rsp_ini_addr_o = rsp_head.ini_addr;
    assign rsp_rdata_o    = rsp_head.rdata;

    // FIFO pointer and count next state
    always_comb begin
        fifo_wptr_d = fifo_push ? ptr_inc(fifo_wptr_q) : fifo_wptr_q;
        fifo_rptr_d = fifo_pop ? ptr_inc(fifo_rptr_q) : fifo_rptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + OccWidth'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - OccWidth'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO control registers; reset discards buffered responses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_wptr_q <= '0;
            fifo_rptr_q <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // FIFO storage, no reset needed since count gates visibility
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_q[fifo_wptr_q] <= push_entry;
        end
    end

`ifndef SYNTHESIS
    // Credit scheme guarantees a free slot whenever an entry must be stored
    always_ff @(posedge clk_i) begin
        if (!rst_i && fifo_push) begin
            assert (fifo_cnt_q < OccWidth'(RspFifoDepth))
            else $error("response FIFO overflow");
        end
    end
`endif

`ifdef TCDM_BANK_RESPONDER_PERF_EN
    logic [31:0] perf_narrow_q, perf_wide_q, perf_stall_q;

    // Saturating performance counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_narrow_q <= '0;
            perf_wide_q   <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (req_hs && !req_wide_i && perf_narrow_q != '1) begin
                perf_narrow_q <= perf_narrow_q + 32'd1;
            end
            if (req_hs && req_wide_i && perf_wide_q != '1) begin
                perf_wide_q <= perf_wide_q + 32'd1;
            end
            if (req_valid_i && !req_ready_o && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_narrow_o = perf_narrow_q;
    assign perf_wide_o   = perf_wide_q;
    assign perf_stall_o  = perf_stall_q;
`else
    assign perf_narrow_o = '0;
    assign perf_wide_o   = '0;
    assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder with three configurations:
// A (latency 1, depth 2), B (latency 3, depth 3), C (latency 2, depth 3).

module tb_tcdm_bank_responder;

`ifdef TCDM_BANK_RESPONDER_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic v, input logic w, input logic [7:0] ini,
                                         input logic [31:0] d);
        return {22'b0, v, w, ini, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: latency 1, depth 2 ----------------
    logic        a_rst, a_req_valid, a_req_ready, a_req_wide, a_req_wen;
    logic [3:0]  a_req_be;
    logic [9:0]  a_req_addr;
    logic [31:0] a_req_wdata;
    logic [7:0]  a_req_ini;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_wide;
    logic [31:0] a_rsp_rdata;
    logic [7:0]  a_rsp_ini;
    logic        a_sram_req, a_sram_we;
    logic [9:0]  a_sram_addr;
    logic [3:0]  a_sram_be;
    logic [31:0] a_sram_wdata, a_sram_rdata;
    logic [31:0] a_perf_narrow, a_perf_wide, a_perf_stall;
    logic [31:0] a_mem [1024];

    tcdm_bank_responder #(.SramLatency(1), .RspFifoDepth(2)) u_dut_a (
        .clk_i(clk), .rst_i(a_rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_wide_i(a_req_wide),
        .req_wen_i(a_req_wen), .req_be_i(a_req_be), .req_addr_i(a_req_addr),
        .req_wdata_i(a_req_wdata), .req_ini_addr_i(a_req_ini),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_wide_o(a_rsp_wide),
        .rsp_rdata_o(a_rsp_rdata), .rsp_ini_addr_o(a_rsp_ini),
        .sram_req_o(a_sram_req), .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr),
        .sram_be_o(a_sram_be), .sram_wdata_o(a_sram_wdata), .sram_rdata_i(a_sram_rdata),
        .perf_narrow_o(a_perf_narrow), .perf_wide_o(a_perf_wide), .perf_stall_o(a_perf_stall)
    );

    // SRAM model A: byte-enabled memory, 1-cycle read, preloaded during reset
    always @(posedge clk) begin
        if (a_rst) begin
            for (int i = 0; i < 1024; i++) a_mem[i] <= 32'h5000_0000 + 32'(i);
        end else if (a_sram_req) begin
            if (a_sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (a_sram_be[b]) a_mem[a_sram_addr][b*8 +: 8] <= a_sram_wdata[b*8 +: 8];
            end
            a_sram_rdata <= a_mem[a_sram_addr];
        end
    end

    task automatic a_drive(input logic v, input logic w, input logic we, input logic [3:0] be,
                           input logic [9:0] addr, input logic [31:0] wd, input logic [7:0] ini);
        a_req_valid = v;
        a_req_wide  = w;
        a_req_wen   = we;
        a_req_be    = be;
        a_req_addr  = addr;
        a_req_wdata = wd;
        a_req_ini   = ini;
    endtask

    // ---------------- instance B: latency 3, depth 3 ----------------
    logic        b_rst, b_req_valid, b_req_ready;
    logic [9:0]  b_req_addr;
    logic [7:0]  b_req_ini;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_wide;
    logic [31:0] b_rsp_rdata;
    logic [7:0]  b_rsp_ini;
    logic        b_sram_req, b_sram_we;
    logic [9:0]  b_sram_addr;
    logic [3:0]  b_sram_be;
    logic [31:0] b_sram_wdata, b_sram_rdata;
    logic [31:0] b_perf_narrow, b_perf_wide, b_perf_stall;
    logic [31:0] b_rd_q [3];

    tcdm_bank_responder #(.SramLatency(3), .RspFifoDepth(3)) u_dut_b (
        .clk_i(clk), .rst_i(b_rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_wide_i(1'b0),
        .req_wen_i(1'b0), .req_be_i(4'hF), .req_addr_i(b_req_addr),
        .req_wdata_i(32'h0), .req_ini_addr_i(b_req_ini),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_wide_o(b_rsp_wide),
        .rsp_rdata_o(b_rsp_rdata), .rsp_ini_addr_o(b_rsp_ini),
        .sram_req_o(b_sram_req), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
        .sram_be_o(b_sram_be), .sram_wdata_o(b_sram_wdata), .sram_rdata_i(b_sram_rdata),
        .perf_narrow_o(b_perf_narrow), .perf_wide_o(b_perf_wide), .perf_stall_o(b_perf_stall)
    );

    // SRAM model B: read-only pattern, 3-cycle latency
    always @(posedge clk) begin
        b_rd_q[0] <= 32'h5000_0000 + 32'(b_sram_addr);
        b_rd_q[1] <= b_rd_q[0];
        b_rd_q[2] <= b_rd_q[1];
    end
    assign b_sram_rdata = b_rd_q[2];

    // ---------------- instance C: latency 2, depth 3 ----------------
    logic        c_rst, c_req_valid, c_req_ready;
    logic [9:0]  c_req_addr;
    logic [7:0]  c_req_ini;
    logic        c_rsp_valid, c_rsp_ready, c_rsp_wide;
    logic [31:0] c_rsp_rdata;
    logic [7:0]  c_rsp_ini;
    logic        c_sram_req, c_sram_we;
    logic [9:0]  c_sram_addr;
    logic [3:0]  c_sram_be;
    logic [31:0] c_sram_wdata, c_sram_rdata;
    logic [31:0] c_perf_narrow, c_perf_wide, c_perf_stall;
    logic [31:0] c_rd_q [2];

    tcdm_bank_responder #(.SramLatency(2), .RspFifoDepth(3)) u_dut_c (
        .clk_i(clk), .rst_i(c_rst),
        .req_valid_i(c_req_valid), .req_ready_o(c_req_ready), .req_wide_i(1'b0),
        .req_wen_i(1'b0), .req_be_i(4'hF), .req_addr_i(c_req_addr),
        .req_wdata_i(32'h0), .req_ini_addr_i(c_req_ini),
        .rsp_valid_o(c_rsp_valid), .rsp_ready_i(c_rsp_ready), .rsp_wide_o(c_rsp_wide),
        .rsp_rdata_o(c_rsp_rdata), .rsp_ini_addr_o(c_rsp_ini),
        .sram_req_o(c_sram_req), .sram_we_o(c_sram_we), .sram_addr_o(c_sram_addr),
        .sram_be_o(c_sram_be), .sram_wdata_o(c_sram_wdata), .sram_rdata_i(c_sram_rdata),
        .perf_narrow_o(c_perf_narrow), .perf_wide_o(c_perf_wide), .perf_stall_o(c_perf_stall)
    );

    // SRAM model C: read-only pattern, 2-cycle latency
    always @(posedge clk) begin
        c_rd_q[0] <= 32'h5000_0000 + 32'(c_sram_addr);
        c_rd_q[1] <= c_rd_q[0];
    end
    assign c_sram_rdata = c_rd_q[1];

    initial begin
        int got;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_drive(1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0, 8'h0);
        a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_ini = '0; b_rsp_ready = 1'b0;
        c_req_valid = 1'b0; c_req_addr = '0; c_req_ini = '0; c_rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        a_req_valid = 1'b1;
        #1;
        check("rst_ready_a", a_req_ready, 0);
        check("rst_sram_req_a", a_sram_req, 0);
        check("rst_rsp_valid_a", a_rsp_valid, 0);
        check("rst_ready_c", c_req_ready, 0);
        check("rst_perf_a", {a_perf_narrow, a_perf_stall}, 0);
        a_req_valid = 1'b0;
        tick();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        #1;
        check("post_rst_ready_a", a_req_ready, 1);
        check("post_rst_rsp_valid_a", a_rsp_valid, 0);

        // Read after write, latency 1
        tick();
        a_rsp_ready = 1'b1;
        a_drive(1'b1, 1'b0, 1'b1, 4'hF, 10'h05, 32'hDEAD_BEEF, 8'd3);
        #1;
        check("raw_wr_ready", a_req_ready, 1);
        check("raw_wr_sram", {a_sram_req, a_sram_we, a_sram_addr, a_sram_be, a_sram_wdata},
              {1'b1, 1'b1, 10'h05, 4'hF, 32'hDEAD_BEEF});
        tick();
        a_req_valid = 1'b0;
        #1;
        check("raw_wr_rsp", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
              pack(1'b1, 1'b0, 8'd3, 32'h0));
        tick();
        a_drive(1'b1, 1'b0, 1'b0, 4'hF, 10'h05, 32'h0, 8'd4);
        #1;
        check("raw_rd_sram", {a_sram_req, a_sram_we, a_sram_addr}, {1'b1, 1'b0, 10'h05});
        check("raw_rd_no_early_rsp", a_rsp_valid, 0);
        tick();
        a_req_valid = 1'b0;
        #1;
        check("raw_rd_rsp", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
              pack(1'b1, 1'b0, 8'd4, 32'hDEAD_BEEF));

        // Partial write over 0xAAAAAAAA
        tick();
        a_drive(1'b1, 1'b0, 1'b1, 4'hF, 10'h10, 32'hAAAA_AAAA, 8'd1);
        tick();
        a_req_valid = 1'b0;
        #1;
        check("pw_full_rsp", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
              pack(1'b1, 1'b0, 8'd1, 32'h0));
        tick();
        a_drive(1'b1, 1'b0, 1'b1, 4'h3, 10'h10, 32'h1122_3344, 8'd2);
        #1;
        check("pw_sram_be", a_sram_be, 4'h3);
        tick();
        a_req_valid = 1'b0;
        #1;
        check("pw_part_rsp", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
              pack(1'b1, 1'b0, 8'd2, 32'h0));
        tick();
        a_drive(1'b1, 1'b0, 1'b0, 4'hF, 10'h10, 32'h0, 8'd5);
        tick();
        a_req_valid = 1'b0;
        #1;
        check("pw_rd_rsp", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
              pack(1'b1, 1'b0, 8'd5, 32'hAAAA_3344));

        // Backpressure with depth 2
        tick();
        a_rsp_ready = 1'b0;
        a_drive(1'b1, 1'b0, 1'b0, 4'hF, 10'h05, 32'h0, 8'd10);
        #1;
        check("bp_acc0", {a_req_ready, a_sram_req}, 2'b11);
        tick();
        a_drive(1'b1, 1'b0, 1'b0, 4'hF, 10'h10, 32'h0, 8'd11);
        #1;
        check("bp_acc1", {a_req_ready, a_sram_req}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            a_drive(1'b1, 1'b0, 1'b0, 4'hF, 10'h20, 32'h0, 8'd12);
            #1;
            check("bp_blocked", {a_req_ready, a_sram_req}, 2'b00);
            check("bp_hold_rsp", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
                  pack(1'b1, 1'b0, 8'd10, 32'hDEAD_BEEF));
        end
        tick();
        a_rsp_ready = 1'b1;
        #1;
        check("bp_no_ready_on_pop", a_req_ready, 0);
        check("bp_rsp0", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
              pack(1'b1, 1'b0, 8'd10, 32'hDEAD_BEEF));
        tick();
        #1;
        check("bp_acc2", a_req_ready, 1);
        check("bp_rsp1", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
              pack(1'b1, 1'b0, 8'd11, 32'hAAAA_3344));
        tick();
        a_drive(1'b1, 1'b0, 1'b0, 4'hF, 10'h21, 32'h0, 8'd13);
        #1;
        check("bp_acc3", a_req_ready, 1);
        check("bp_rsp2", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
              pack(1'b1, 1'b0, 8'd12, 32'h5000_0020));
        tick();
        a_req_valid = 1'b0;
        #1;
        check("bp_rsp3", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
              pack(1'b1, 1'b0, 8'd13, 32'h5000_0021));
        tick();
        #1;
        check("bp_drained", a_rsp_valid, 0);

        // Wide tagging: even ini wide, odd ini narrow
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i < 8) a_drive(1'b1, (i % 2) == 0, 1'b0, 4'hF, 10'(10'h30 + i), 32'h0, 8'(i));
            else       a_req_valid = 1'b0;
            #1;
            if (i < 8) check("wt_acc", {a_req_ready, a_sram_req}, 2'b11);
            if (i > 0) check("wt_rsp", pack(a_rsp_valid, a_rsp_wide, a_rsp_ini, a_rsp_rdata),
                             pack(1'b1, ((i - 1) % 2) == 0, 8'(i - 1), 32'h5000_0030 + 32'(i - 1)));
        end
        tick();
        #1;
        check("wt_drained", a_rsp_valid, 0);
        check("perf_narrow", a_perf_narrow, PerfEn ? 32'd13 : 32'd0);
        check("perf_wide", a_perf_wide, PerfEn ? 32'd4 : 32'd0);
        check("perf_stall", a_perf_stall, PerfEn ? 32'd4 : 32'd0);

        // Reset mid-flight, latency 3
        tick();
        b_req_valid = 1'b1; b_req_addr = 10'h1; b_req_ini = 8'd1;
        #1;
        check("mf_acc0", {b_req_ready, b_sram_req}, 2'b11);
        tick();
        b_req_addr = 10'h2; b_req_ini = 8'd2;
        #1;
        check("mf_acc1", {b_req_ready, b_sram_req}, 2'b11);
        tick();
        b_req_valid = 1'b0;
        b_rst = 1'b1;
        #1;
        check("mf_rst_outs", {b_req_ready, b_rsp_valid}, 2'b00);
        tick();
        b_rst = 1'b0;
        b_rsp_ready = 1'b1;
        #1;
        check("mf_ready_after", b_req_ready, 1);
        check("mf_no_rsp", b_rsp_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            check("mf_no_rsp_later", b_rsp_valid, 0);
        end
        // Three credits available after reset proves occupancy restarted at zero
        b_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            b_req_valid = 1'b1; b_req_addr = 10'(10'h40 + i); b_req_ini = 8'(20 + i);
            #1;
            check("mf_credit", b_req_ready, i < 3);
        end
        check("mf_first_rsp", pack(b_rsp_valid, b_rsp_wide, b_rsp_ini, b_rsp_rdata),
              pack(1'b1, 1'b0, 8'd20, 32'h5000_0040));
        tick();
        b_req_valid = 1'b0;
        b_rsp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            #1;
            if (b_rsp_valid) begin
                check("mf_drain", pack(b_rsp_valid, b_rsp_wide, b_rsp_ini, b_rsp_rdata),
                      pack(1'b1, 1'b0, 8'(20 + got), 32'h5000_0040 + 32'(got)));
                got++;
            end
            tick();
        end
        check("mf_drain_count", got, 3);
        #1;
        check("mf_drained", {b_rsp_valid, b_req_ready}, 2'b01);

        // Streaming, latency 2, depth 3
        c_rsp_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i < 16) begin
                c_req_valid = 1'b1; c_req_addr = 10'(i); c_req_ini = 8'(i);
            end else begin
                c_req_valid = 1'b0;
            end
            #1;
            if (i < 16) check("st_acc", {c_req_ready, c_sram_req}, 2'b11);
            if (i >= 2) check("st_rsp", pack(c_rsp_valid, c_rsp_wide, c_rsp_ini, c_rsp_rdata),
                              pack(1'b1, 1'b0, 8'(i - 2), 32'h5000_0000 + 32'(i - 2)));
            else        check("st_latency", c_rsp_valid, 0);
        end
        tick();
        #1;
        check("st_drained", c_rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
